// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one single-port RAM between pixel fetch (A) and CPU (B)
module ram_port_arbiter #(
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk50,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_urgent,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_in,
    output logic          ram_load,
    input  logic [DW-1:0] ram_out
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    port_e              last_q, last_d;
    logic [WCW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [RD_LAT-1:0]  a_tag_q, a_tag_d;
    logic [RD_LAT-1:0]  b_tag_q, b_tag_d;
    logic               a_rvalid_q, a_rvalid_d;
    logic               b_rvalid_q, b_rvalid_d;
    logic [DW-1:0]      a_rdata_q, a_rdata_d;
    logic [DW-1:0]      b_rdata_q, b_rdata_d;
    logic               sel_a, sel_b;

    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (b_req && wait_cnt_q == WAIT_MAX) begin
            sel_b = 1'b1;
        end else if (a_req && a_urgent) begin
            sel_a = 1'b1;
        end else if (a_req && b_req) begin
            if (last_q == PORT_B) sel_a = 1'b1;
            else                  sel_b = 1'b1;
        end else if (a_req) begin
            sel_a = 1'b1;
        end else if (b_req) begin
            sel_b = 1'b1;
        end

        // Grants are the only path to the RAM, so gating them covers ram_load too.
        a_gnt = sel_a & ~reset;
        b_gnt = sel_b & ~reset;

        ram_address = b_gnt ? b_addr  : a_addr;
        ram_in      = b_gnt ? b_wdata : a_wdata;
        ram_load    = (a_gnt & a_we) | (b_gnt & b_we);

        last_d = last_q;
        if (a_gnt)      last_d = PORT_A;
        else if (b_gnt) last_d = PORT_B;

        wait_cnt_d = '0;
        if (b_req && !b_gnt)
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WCW'(1);

        a_tag_d    = '0;
        b_tag_d    = '0;
        a_tag_d[0] = a_gnt & ~a_we;
        b_tag_d[0] = b_gnt & ~b_we;
        for (int i = 1; i < RD_LAT; i++) begin
            a_tag_d[i] = a_tag_q[i-1];
            b_tag_d[i] = b_tag_q[i-1];
        end

        // A tag leaving the pipe marks the cycle ram_out belongs to that port.
        a_rvalid_d = a_tag_q[RD_LAT-1];
        b_rvalid_d = b_tag_q[RD_LAT-1];
        a_rdata_d  = a_tag_q[RD_LAT-1] ? ram_out : a_rdata_q;
        b_rdata_d  = b_tag_q[RD_LAT-1] ? ram_out : b_rdata_q;

        a_rvalid = a_rvalid_q & ~reset;
        b_rvalid = b_rvalid_q & ~reset;
        a_rdata  = reset ? '0 : a_rdata_q;
        b_rdata  = reset ? '0 : b_rdata_q;
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            last_q     <= PORT_B;
            wait_cnt_q <= '0;
            a_tag_q    <= '0;
            b_tag_q    <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
            a_tag_q    <= a_tag_d;
            b_tag_q    <= b_tag_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

endmodule
